// File: rtl/vlog_tb_pkg.sv
// Shared definitions for the serializer slice: state encoding, width limit and a
// constant-friendly ceil(log2) helper.
package vlog_tb_pkg;

    localparam int unsigned MAX_W = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT,
        StGap   = ST_GAP
    } state_e;

    // Never returns less than 1 so a single-state counter still has a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vlog_bit_counter.sv
// Modulo-N up counter with synchronous clear, enable and a terminal-count flag.
module vlog_bit_counter #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 3
) (
    input  logic          clk_i,
    input  logic          clear_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q;

    assign tc_o    = (count_q == CW'(N - 1));
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= tc_o ? '0 : count_q + CW'(1);
        end
    end

endmodule

// File: rtl/vlog_serializer.sv
// Parallel-to-serial stage: takes a W-bit word on valid/ready, shifts it out one bit per
// clock on x, then holds x at IDLE_LEVEL for GAP cycles before accepting the next word.
module vlog_serializer
    import vlog_tb_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP        = 1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         x,
    output logic         busy,
    output logic         frame_done
);

    localparam int unsigned BitCw = clog2(W);
    localparam int unsigned GapN  = (GAP == 0) ? 1 : GAP;

    state_e           state_q;
    logic [W-1:0]     shreg_q;
    logic             x_q;
    logic             busy_q;
    logic             done_q;
    logic [BitCw-1:0] bit_cnt;
    logic             bit_tc;
    logic [7:0]       gap_cnt;
    logic             gap_tc;
    logic             unused_gap_cnt;
    logic             xfer;
    logic             load_bit;
    logic [W-1:0]     load_rest;
    logic             next_bit;
    logic [W-1:0]     next_rest;

    vlog_bit_counter #(
        .N (W),
        .CW(BitCw)
    ) u_bit_cnt (
        .clk_i  (clk),
        .clear_i(reset),
        .en_i   (state_q == StShift),
        .count_o(bit_cnt),
        .tc_o   (bit_tc)
    );

    vlog_bit_counter #(
        .N (GapN),
        .CW(8)
    ) u_gap_cnt (
        .clk_i  (clk),
        .clear_i(reset),
        .en_i   (state_q == StGap),
        .count_o(gap_cnt),
        .tc_o   (gap_tc)
    );

    assign unused_gap_cnt = ^gap_cnt;

    // With no gap the next word is taken during the last bit so frames abut on x.
    assign in_ready = !reset &&
                      ((state_q == StIdle) || ((GAP == 0) && (state_q == StShift) && bit_tc));
    assign xfer     = in_valid && in_ready;

    assign load_bit  = MSB_FIRST ? in_data[W-1] : in_data[0];
    assign load_rest = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
    assign next_bit  = MSB_FIRST ? shreg_q[W-1] : shreg_q[0];
    assign next_rest = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            x_q     <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        state_q <= StShift;
                        shreg_q <= load_rest;
                        x_q     <= load_bit;
                        busy_q  <= 1'b1;
                        done_q  <= (W == 1);
                    end
                end
                StShift: begin
                    if (!bit_tc) begin
                        shreg_q <= next_rest;
                        x_q     <= next_bit;
                        // Flag the cycle that will carry the final bit.
                        done_q  <= (W >= 2) && (bit_cnt == BitCw'(W - 2));
                    end else if (GAP != 0) begin
                        state_q <= StGap;
                        x_q     <= IDLE_LEVEL;
                        done_q  <= 1'b0;
                    end else if (xfer) begin
                        shreg_q <= load_rest;
                        x_q     <= load_bit;
                        done_q  <= (W == 1);
                    end else begin
                        state_q <= StIdle;
                        x_q     <= IDLE_LEVEL;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                StGap: begin
                    if (gap_tc) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    x_q     <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x          = x_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_vlog_serializer.sv
// Bench for vlog_serializer: four parameterisations side by side, directed vector tables
// plus randomized traffic against a per-cycle queue model of the expected serial output.
module tb_vlog_serializer;

    localparam int unsigned PW  [4] = '{8, 8, 4, 1};
    localparam bit          PM  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam int unsigned PG  [4] = '{1, 0, 3, 0};
    localparam bit          PIL [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst, vld, rdy, xo, bsy, fdn;
    logic [7:0]  din0, din1;
    logic [3:0]  din2;
    logic [0:0]  din3;
    logic [63:0] din [4];

    vlog_serializer #(.W(8), .MSB_FIRST(1'b1), .GAP(1), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .reset(rst[0]), .in_data(din0), .in_valid(vld[0]), .in_ready(rdy[0]),
        .x(xo[0]), .busy(bsy[0]), .frame_done(fdn[0]));
    vlog_serializer #(.W(8), .MSB_FIRST(1'b0), .GAP(0), .IDLE_LEVEL(1'b0)) dut1 (
        .clk(clk), .reset(rst[1]), .in_data(din1), .in_valid(vld[1]), .in_ready(rdy[1]),
        .x(xo[1]), .busy(bsy[1]), .frame_done(fdn[1]));
    vlog_serializer #(.W(4), .MSB_FIRST(1'b1), .GAP(3), .IDLE_LEVEL(1'b1)) dut2 (
        .clk(clk), .reset(rst[2]), .in_data(din2), .in_valid(vld[2]), .in_ready(rdy[2]),
        .x(xo[2]), .busy(bsy[2]), .frame_done(fdn[2]));
    vlog_serializer #(.W(1), .MSB_FIRST(1'b1), .GAP(0), .IDLE_LEVEL(1'b0)) dut3 (
        .clk(clk), .reset(rst[3]), .in_data(din3), .in_valid(vld[3]), .in_ready(rdy[3]),
        .x(xo[3]), .busy(bsy[3]), .frame_done(fdn[3]));

    // Model: per DUT, a FIFO of future cycles, each entry {busy, frame_done, x}.
    logic [2:0] rb [4][256];
    int         rp [4];
    int         nq [4];
    logic [2:0] cur [4];
    logic [3:0] rst_prev;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        int          d;
        logic        r;
        logic        v;
        logic [63:0] data;
        logic        ex, eb, ef, er;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int d, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %b want %b", name, d, $time, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [2:0] e);
        rb[d][(rp[d] + nq[d]) % 256] = e;
        nq[d]++;
    endtask

    task automatic push_frame(input int d, input logic [63:0] data);
        for (int i = 0; i < int'(PW[d]); i++) begin
            int idx;
            idx = PM[d] ? int'(PW[d]) - 1 - i : i;
            push(d, {1'b1, i == int'(PW[d]) - 1, data[idx]});
        end
        for (int g = 0; g < int'(PG[d]); g++) push(d, {1'b1, 1'b0, PIL[d]});
    endtask

    // Advance one clock and compare the registered outputs with the model.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            if (rst_prev[d] || nq[d] == 0) begin
                cur[d] = {2'b00, PIL[d]};
                if (rst_prev[d]) nq[d] = 0;
            end else begin
                cur[d] = rb[d][rp[d]];
                rp[d]  = (rp[d] + 1) % 256;
                nq[d]--;
            end
            check("x", d, xo[d], cur[d][0]);
            check("busy", d, bsy[d], cur[d][2]);
            check("frame_done", d, fdn[d], cur[d][1]);
        end
    endtask

    // Present the new inputs, check in_ready, and queue any accepted frame.
    task automatic settle();
        din0 = din[0][7:0];
        din1 = din[1][7:0];
        din2 = din[2][3:0];
        din3 = din[3][0:0];
        #1;
        for (int d = 0; d < 4; d++) begin
            logic er;
            er = !rst[d] && nq[d] == 0 && (!cur[d][2] || (PG[d] == 0 && cur[d][1]));
            check("in_ready", d, rdy[d], er);
            if (vld[d] && er) push_frame(d, din[d]);
            rst_prev[d] = rst[d];
        end
    endtask

    function automatic void add(input int d, input logic r, input logic v,
                                input logic [63:0] data, input logic ex, input logic eb,
                                input logic ef, input logic er);
        vec_t t;
        t.d = d; t.r = r; t.v = v; t.data = data;
        t.ex = ex; t.eb = eb; t.ef = ef; t.er = er;
        vecs.push_back(t);
    endfunction

    initial begin
        logic [7:0] pa;
        vec_t t;
        pa = 8'hA5;

        // dut0: reset with valid high, then 8'hA5 MSB first with one gap cycle
        add(0, I, I, 64'hA5, O, O, O, O);
        add(0, O, I, 64'hA5, O, O, O, I);
        for (int i = 0; i < 8; i++) add(0, O, O, 64'hFF, pa[7-i], I, i == 7, O);
        add(0, O, O, 64'hFF, O, I, O, O);
        add(0, O, O, 64'hFF, O, O, O, I);
        // dut1: LSB first, no gap, 8'h01 then 8'h80 contiguous
        add(1, O, I, 64'h01, O, O, O, I);
        for (int i = 0; i < 8; i++) add(1, O, I, 64'h80, i == 0, I, i == 7, i == 7);
        for (int i = 0; i < 8; i++) add(1, O, O, 64'h00, i == 7, I, i == 7, i == 7);
        add(1, O, O, 64'h00, O, O, O, I);
        // dut2: W=4, GAP=3, idle level high
        add(2, O, I, 64'h0, I, O, O, I);
        for (int i = 0; i < 4; i++) add(2, O, O, 64'hF, O, I, i == 3, O);
        for (int g = 0; g < 3; g++) add(2, O, O, 64'hF, I, I, O, O);
        add(2, O, O, 64'hF, I, O, O, I);
        // dut0: reset while bit 3 is on x, then a clean 8'hFF frame
        add(0, O, I, 64'hA5, O, O, O, I);
        add(0, O, O, 64'hA5, I, I, O, O);
        add(0, O, O, 64'hA5, O, I, O, O);
        add(0, O, O, 64'hA5, I, I, O, O);
        add(0, I, O, 64'hA5, O, I, O, O);
        add(0, O, I, 64'hFF, O, O, O, I);
        for (int i = 0; i < 8; i++) add(0, O, O, 64'h00, I, I, i == 7, O);
        add(0, O, O, 64'h00, O, I, O, O);
        add(0, O, O, 64'h00, O, O, O, I);
        // dut3: W=1 back-to-back 1,0,1
        add(3, O, I, 64'h1, O, O, O, I);
        add(3, O, I, 64'h0, I, I, I, I);
        add(3, O, I, 64'h1, O, I, I, I);
        add(3, O, O, 64'h0, I, I, I, I);
        add(3, O, O, 64'h0, O, O, O, I);

        for (int d = 0; d < 4; d++) begin
            rp[d] = 0;
            nq[d] = 0;
            din[d] = '0;
        end
        rst = 4'hF;
        vld = 4'hF;
        rst_prev = 4'hF;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        tick();
        settle();

        for (int k = 0; k < vecs.size(); k++) begin
            t = vecs[k];
            tick();
            check("tbl_x", t.d, xo[t.d], t.ex);
            check("tbl_busy", t.d, bsy[t.d], t.eb);
            check("tbl_frame_done", t.d, fdn[t.d], t.ef);
            rst = '0;
            vld = '0;
            rst[t.d] = t.r;
            vld[t.d] = t.v;
            din[t.d] = t.data;
            settle();
            check("tbl_in_ready", t.d, rdy[t.d], t.er);
        end

        for (int c = 0; c < 1000; c++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                rst[d] = ($urandom_range(0, 63) == 0);
                vld[d] = ($urandom_range(0, 3) != 0);
                din[d] = {$urandom(), $urandom()};
            end
            settle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
